// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch line sequencer.
package fetch_pkg;

  localparam int unsigned LINE_BYTES    = 64;
  localparam int unsigned INST_PER_LINE = 16;
  localparam int unsigned LINE_OFS_W    = 6;
  localparam int unsigned OFFSET_W      = $clog2(INST_PER_LINE);
  localparam int unsigned LINE_W        = LINE_BYTES * 8;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    PUSH,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_rsp_buf.sv
// Holding register for one icache line plus its line PC and first-word offset.
// Clear wins over load so a squash in the same cycle as a capture leaves it empty.
module fetch_rsp_buf #(
  parameter int unsigned PC_W = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic                            clear,
  input  logic [fetch_pkg::LINE_W-1:0]    load_data,
  input  logic [PC_W-1:0]                 load_pc,
  input  logic [fetch_pkg::OFFSET_W-1:0]  load_offset,
  output logic                            valid,
  output logic [fetch_pkg::LINE_W-1:0]    data,
  output logic [PC_W-1:0]                 pc,
  output logic [fetch_pkg::OFFSET_W-1:0]  offset
);

  import fetch_pkg::*;

  // Valid flag: clear has priority over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload capture; contents are only meaningful while valid is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data   <= '0;
      pc     <= '0;
      offset <= '0;
    end else if (load && !clear) begin
      data   <= load_data;
      pc     <= load_pc;
      offset <= load_offset;
    end
  end

endmodule

// File: rtl/fetch_line_ctrl.sv
// Fetch line sequencer: issues line-aligned icache requests (one outstanding),
// buffers each response and pushes it into the instruction queue.
// Backend redirects restart fetch, flush the queue and drop stale responses.
// Optional build macro FETCH_PERF_CNT_EN adds two saturating perf counters.
module fetch_line_ctrl #(
  parameter int unsigned     PC_W       = 64,
  parameter int unsigned     LINE_BYTES = fetch_pkg::LINE_BYTES,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(fetch_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_vld_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic            ic_req_vld_o,
  input  logic            ic_req_rdy_i,
  output logic [PC_W-1:0] ic_req_pc_o,
  input  logic            ic_rsp_vld_i,
  input  logic [511:0]    ic_rsp_data_i,
  output logic            iq_valid_o,
  output logic [PC_W-1:0] iq_pc_o,
  output logic [3:0]      iq_offset_o,
  output logic [511:0]    iq_data_o,
  input  logic            iq_full_i,
  output logic            iq_flush_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_full_stall_o,
  output logic [31:0]     perf_redirect_o
`endif
);

  import fetch_pkg::*;

  fetch_state_e          state_q;
  logic [PC_W-1:0]       fetch_pc_q;
  logic [OFFSET_W-1:0]   offset_q;
  logic                  req_vld_q;
  logic                  flush_q;

  logic [PC_W-1:0]       line_pc;
  logic                  buf_valid;
  logic                  buf_load;
  logic                  buf_clear;
  logic                  push_fire;

  assign line_pc      = {fetch_pc_q[PC_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};

  assign ic_req_vld_o = req_vld_q;
  assign ic_req_pc_o  = req_vld_q ? line_pc : '0;
  assign iq_flush_o   = flush_q;

  // A redirect masks the push combinationally so no line escapes in the squash cycle.
  assign iq_valid_o   = buf_valid & ~redirect_vld_i;
  assign push_fire    = iq_valid_o & ~iq_full_i;
  assign buf_load     = (state_q == WAIT) & ic_rsp_vld_i & ~redirect_vld_i;
  assign buf_clear    = push_fire | redirect_vld_i;

  fetch_rsp_buf #(
    .PC_W (PC_W)
  ) u_rsp_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (buf_load),
    .clear       (buf_clear),
    .load_data   (ic_rsp_data_i),
    .load_pc     (line_pc),
    .load_offset (offset_q),
    .valid       (buf_valid),
    .data        (iq_data_o),
    .pc          (iq_pc_o),
    .offset      (iq_offset_o)
  );

  // Main sequencer: state, fetch PC/offset and registered request/flush outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      offset_q   <= RESET_PC[LINE_OFS_W-1:2];
      req_vld_q  <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      flush_q <= redirect_vld_i;
      if (redirect_vld_i) begin
        fetch_pc_q <= redirect_pc_i;
        offset_q   <= redirect_pc_i[LINE_OFS_W-1:2];
        // An accepted request or a missing response leaves a stale reply in flight.
        unique case (state_q)
          REQ: begin
            state_q   <= ic_req_rdy_i ? DRAIN : REQ;
            req_vld_q <= ~ic_req_rdy_i;
          end
          WAIT: begin
            state_q   <= ic_rsp_vld_i ? REQ : DRAIN;
            req_vld_q <= ic_rsp_vld_i;
          end
          DRAIN: begin
            state_q   <= DRAIN;
            req_vld_q <= 1'b0;
          end
          default: begin
            state_q   <= REQ;
            req_vld_q <= 1'b1;
          end
        endcase
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q   <= REQ;
            req_vld_q <= 1'b1;
          end
          REQ: begin
            if (ic_req_rdy_i) begin
              state_q   <= WAIT;
              req_vld_q <= 1'b0;
            end
          end
          WAIT: begin
            if (ic_rsp_vld_i) begin
              state_q <= PUSH;
            end
          end
          PUSH: begin
            if (push_fire) begin
              fetch_pc_q <= fetch_pc_q + PC_W'(LINE_BYTES);
              offset_q   <= '0;
              state_q    <= REQ;
              req_vld_q  <= 1'b1;
            end
          end
          DRAIN: begin
            if (ic_rsp_vld_i) begin
              state_q   <= REQ;
              req_vld_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= IDLE;
            req_vld_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: queue-full stall cycles in PUSH and redirect events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_stall_o <= '0;
      perf_redirect_o   <= '0;
    end else begin
      if ((state_q == PUSH) && iq_full_i && (perf_full_stall_o != '1)) begin
        perf_full_stall_o <= perf_full_stall_o + 32'd1;
      end
      if (redirect_vld_i && (perf_redirect_o != '1)) begin
        perf_redirect_o <= perf_redirect_o + 32'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: doc/fetch_line_ctrl.md
Name: fetch_line_ctrl

Overview:
- Front-end sequencer between next-line PC generation, the icache, and the 16-entry-per-write instruction queue.
- Issues line-aligned icache requests and buffers each 512-bit response.
- Pushes each response into the instruction queue only when the queue reports not-full.
- On backend redirect: restarts fetch, flushes the queue, and drops any stale in-flight icache response.
- One request outstanding at most.

Parameters:
- PC_W, 64, program counter width.
- LINE_BYTES, 64, icache line size in bytes; 16 instructions of 32 bits.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- redirect_vld_i  in  1  backend redirect/squash, single-cycle pulse.
- redirect_pc_i  in  PC_W  redirect target PC.
- ic_req_vld_o  out  1  icache request valid.
- ic_req_rdy_i  in  1  icache accepts request.
- ic_req_pc_o  out  PC_W  line-aligned request address.
- ic_rsp_vld_i  in  1  icache response valid, one cycle, no back-pressure.
- ic_rsp_data_i  in  512  response line.
- iq_valid_o  out  1  push line into instruction queue.
- iq_pc_o  out  PC_W  line-aligned PC of pushed line.
- iq_offset_o  out  4  word index of the first useful instruction in the line.
- iq_data_o  out  512  pushed line.
- iq_full_i  in  1  instruction queue cannot accept 16 instructions.
- iq_flush_o  out  1  one-cycle flush to the instruction queue.

Behaviour:
- Reset values: all outputs 0.
  - fetch_pc = RESET_PC; offset = RESET_PC[5:2].
  - State IDLE.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: ic_req_vld_o=1, ic_req_pc_o={fetch_pc[PC_W-1:6],6'b0}. Request, PC and valid are held stable until ic_req_rdy_i=1, then go to WAIT.
  - WAIT: on ic_rsp_vld_i, capture data into the line buffer, go to PUSH.
  - PUSH: iq_valid_o=1, driven combinationally from the buffer valid.
    - iq_pc_o = line PC; iq_offset_o = offset.
    - Transfer occurs in any cycle with iq_valid_o=1 and iq_full_i=0.
    - On transfer: fetch_pc += LINE_BYTES, offset = 0, go to REQ.
    - iq_valid_o is held with identical data while iq_full_i=1.
  - DRAIN: wait for the stale response, discard it, then go to REQ.
- Redirect has highest priority in every state:
  - fetch_pc = redirect_pc_i; offset = redirect_pc_i[5:2].
  - iq_flush_o=1 in the next cycle.
  - iq_valid_o is suppressed in the redirect cycle, so no push occurs that cycle.
- Redirect target state:
  - REQ without handshake: go to REQ with the new address.
  - REQ with handshake in the same cycle: go to DRAIN.
  - WAIT without response in the same cycle: go to DRAIN.
  - WAIT with response in the same cycle: response is dropped, go to REQ.
  - PUSH: buffer invalidated, go to REQ.
  - DRAIN: stays in DRAIN, PC updated.
  - IDLE: go to REQ with the new PC.
- Address arithmetic: PC increment wraps modulo 2^PC_W. Low 6 bits are always zero on ic_req_pc_o and iq_pc_o.
- ic_rsp_vld_i outside WAIT/DRAIN is a protocol error; it is ignored and flagged by a bench assertion.
- Reset asserted mid-operation: immediate return to reset values. Any later response is ignored, because the block is in IDLE/REQ.

Optional Feature:
- FETCH_PERF_CNT_EN: adds two 32-bit saturating output counters.
  - perf_full_stall_o: cycles in PUSH with iq_full_i=1.
  - perf_redirect_o: redirect count.
  - Both counters reset to 0.
- Without the macro: no counter ports or logic exist.

Decomposition:
- Package fetch_pkg:
  - state enum IDLE/REQ/WAIT/PUSH/DRAIN.
  - LINE_BYTES, INST_PER_LINE=16, LINE_OFS_W=6.
  - RESET_PC default.
- Sub-module fetch_rsp_buf: 512-bit data plus PC plus offset holding register with valid, load, and clear. Clear has priority over load.

Test Plan:
- Reset release, ic_req_rdy_i=1, responses 2 cycles later, iq_full_i=0:
  - ic_req_pc_o = 0x8000_0000, then 0x8000_0040, then 0x8000_0080.
  - Each iq_valid_o is one cycle, with offset 0.
- iq_full_i=1 for 5 cycles in PUSH:
  - iq_valid_o stays high 6 cycles with stable data/PC.
  - No new request until transfer; perf_full_stall_o=5 with macro.
- Redirect to 0x8000_1234 while in WAIT:
  - iq_flush_o pulses next cycle; the next response is dropped (no iq_valid_o).
  - Next request is 0x8000_1200; its push has iq_offset_o=13.
- Redirect in the same cycle as request handshake: state goes to DRAIN, the old response is dropped, then a request for the new line is issued.
- Redirect in the same cycle as iq_full_i=0 in PUSH: no push, iq_flush_o=1, next request is the redirect line.
- fetch_pc = 0xFFFF_FFFF_FFFF_FFC0 pushed: next ic_req_pc_o = 0x0 (wrap-around).
